generator_pwm_multi: RTL and testbench



---
 rtl/generator_pwm_multi.sv | 160 ++++++++++++++++
 tb/tb_generator_pwm_multi.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/generator_pwm_multi.sv
// Multi-channel PWM generator: one shared period counter, per-channel duty compare,
// direction dead-time FSM. Define PWM_RAMP_EN to slew-limit duty changes per period.
module generator_pwm_multi #(
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = 12,
    parameter int PERIOD_RST = 999,
    parameter int DEAD_CYC   = 50,
    parameter int RAMP_STEP  = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    activ,
    input  logic [CNT_W-1:0]        period,
    input  logic [NUM_CH*CNT_W-1:0] duty,
    input  logic [NUM_CH-1:0]       dir,
    output logic [NUM_CH-1:0]       pwm_a,
    output logic [NUM_CH-1:0]       pwm_b,
    output logic [CNT_W-1:0]        cnt_out,
    output logic                    period_start
);
    localparam int DEAD_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LD = DEAD_W'(DEAD_CYC - 1);
`ifdef PWM_RAMP_EN
    localparam logic [CNT_W-1:0] STEP = CNT_W'(RAMP_STEP);
`endif

    typedef enum logic {S_RUN = 1'b0, S_DEAD = 1'b1} ch_state_e;

    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_period_act;
    logic              w_wrap;
    logic [NUM_CH-1:0] w_a_nxt;
    logic [NUM_CH-1:0] w_b_nxt;
    logic [NUM_CH-1:0] r_pwm_a;
    logic [NUM_CH-1:0] r_pwm_b;

    assign w_wrap = (r_cnt == r_period_act);

    // Period shadow loads only at the wrap so a new period never truncates a running one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt        <= '0;
            r_period_act <= CNT_W'(PERIOD_RST);
        end else if (!activ) begin
            r_cnt        <= '0;
            r_period_act <= period;
        end else if (w_wrap) begin
            r_cnt        <= '0;
            r_period_act <= period;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            logic [CNT_W-1:0]  r_duty;
            logic [CNT_W-1:0]  w_tgt;
            logic              w_raw;
            ch_state_e         r_state;
            ch_state_e         w_state_nxt;
            logic              r_dir;
            logic              w_dir_nxt;
            logic [DEAD_W-1:0] r_dead;
            logic [DEAD_W-1:0] w_dead_nxt;

            assign w_tgt = duty[i*CNT_W +: CNT_W];
            assign w_raw = (r_cnt < r_duty);

            always_comb begin
                w_state_nxt = r_state;
                w_dir_nxt   = r_dir;
                w_dead_nxt  = r_dead;
                case (r_state)
                    S_RUN: begin
                        if (dir[i] != r_dir) begin
                            w_state_nxt = S_DEAD;
                            w_dead_nxt  = DEAD_LD;
                        end
                    end
                    S_DEAD: begin
                        if (r_dead == '0) begin
                            w_state_nxt = S_RUN;
                            w_dir_nxt   = dir[i];
                        end else begin
                            w_dead_nxt = r_dead - DEAD_W'(1);
                        end
                    end
                    default: w_state_nxt = S_RUN;
                endcase
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_state <= S_RUN;
                    r_dir   <= 1'b0;
                    r_dead  <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    r_dir   <= w_dir_nxt;
                    r_dead  <= w_dead_nxt;
                end
            end

            // Next-state gating blanks the outputs on the very edge the reversal is seen.
            assign w_a_nxt[i] = activ & (w_state_nxt == S_RUN) & ~w_dir_nxt & w_raw;
            assign w_b_nxt[i] = activ & (w_state_nxt == S_RUN) &  w_dir_nxt & w_raw;

`ifdef PWM_RAMP_EN
            logic             w_restart;
            logic [CNT_W-1:0] w_ramp;

            assign w_restart = (r_state == S_DEAD) && (r_dead == '0) && (dir[i] != r_dir);

            always_comb begin
                w_ramp = w_tgt;
                if (w_tgt > r_duty && (w_tgt - r_duty) > STEP)
                    w_ramp = r_duty + STEP;
                else if (r_duty > w_tgt && (r_duty - w_tgt) > STEP)
                    w_ramp = r_duty - STEP;
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n)
                    r_duty <= '0;
                else if (!activ)
                    r_duty <= w_tgt;
                else if (w_restart)
                    r_duty <= '0;
                else if (w_wrap)
                    r_duty <= w_ramp;
            end
`else
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n)
                    r_duty <= '0;
                else if (!activ || w_wrap)
                    r_duty <= w_tgt;
            end
`endif
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pwm_a <= '0;
            r_pwm_b <= '0;
        end else begin
            r_pwm_a <= w_a_nxt;
            r_pwm_b <= w_b_nxt;
        end
    end

    assign pwm_a        = r_pwm_a;
    assign pwm_b        = r_pwm_b;
    assign cnt_out      = r_cnt;
    assign period_start = activ & reset_n & (r_cnt == '0);

endmodule

// File: tb/tb_generator_pwm_multi.sv
// Randomized self-checking bench for generator_pwm_multi against a behavioural model.
module tb_generator_pwm_multi;
    localparam int NUM_CH     = 2;
    localparam int CNT_W      = 12;
    localparam int PERIOD_RST = 999;
    localparam int DEAD_CYC   = 50;
    localparam int RAMP_STEP  = 8;
    localparam int VW         = 2*NUM_CH + CNT_W + 1;

    logic                    clock   = 1'b0;
    logic                    reset_n = 1'b1;
    logic                    activ   = 1'b0;
    logic [CNT_W-1:0]        period  = '0;
    logic [NUM_CH*CNT_W-1:0] duty    = '0;
    logic [NUM_CH-1:0]       dir     = '0;
    logic [NUM_CH-1:0]       pwm_a;
    logic [NUM_CH-1:0]       pwm_b;
    logic [CNT_W-1:0]        cnt_out;
    logic                    period_start;

    int n_chk  = 0;
    int n_fail = 0;

    generator_pwm_multi #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PERIOD_RST(PERIOD_RST),
        .DEAD_CYC(DEAD_CYC), .RAMP_STEP(RAMP_STEP)
    ) dut (
        .clock(clock), .reset_n(reset_n), .activ(activ), .period(period),
        .duty(duty), .dir(dir), .pwm_a(pwm_a), .pwm_b(pwm_b),
        .cnt_out(cnt_out), .period_start(period_start)
    );

    always #10 clock = ~clock;

    // Reference model: integer counter, per-channel duty and remaining dead-time (-1 = running).
    int                m_cnt = 0;
    int                m_per = PERIOD_RST;
    int                m_duty [NUM_CH];
    bit                m_dir  [NUM_CH];
    int                m_left [NUM_CH];
    logic [NUM_CH-1:0] m_a = '0;
    logic [NUM_CH-1:0] m_b = '0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_cnt = 0;
            m_per = PERIOD_RST;
            m_a   = '0;
            m_b   = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_duty[c] = 0;
                m_dir[c]  = 1'b0;
                m_left[c] = -1;
            end
        end else begin
            bit restart [NUM_CH];
            bit raw;
            bit wrap;
            int tgt;
            for (int c = 0; c < NUM_CH; c++) begin
                raw        = (m_cnt < m_duty[c]);
                restart[c] = 1'b0;
                if (m_left[c] < 0) begin
                    if (dir[c] != m_dir[c]) m_left[c] = DEAD_CYC - 1;
                end else if (m_left[c] == 0) begin
                    restart[c] = (dir[c] != m_dir[c]);
                    m_dir[c]   = dir[c];
                    m_left[c]  = -1;
                end else begin
                    m_left[c] = m_left[c] - 1;
                end
                m_a[c] = activ && (m_left[c] < 0) && !m_dir[c] && raw;
                m_b[c] = activ && (m_left[c] < 0) &&  m_dir[c] && raw;
            end
            wrap = (m_cnt == m_per);
            for (int c = 0; c < NUM_CH; c++) begin
                tgt = int'(duty[c*CNT_W +: CNT_W]);
                if (!activ) m_duty[c] = tgt;
`ifdef PWM_RAMP_EN
                else if (restart[c]) m_duty[c] = 0;
                else if (wrap) begin
                    if (tgt > m_duty[c]) m_duty[c] = (tgt - m_duty[c] > RAMP_STEP) ? m_duty[c] + RAMP_STEP : tgt;
                    else                 m_duty[c] = (m_duty[c] - tgt > RAMP_STEP) ? m_duty[c] - RAMP_STEP : tgt;
                end
`else
                else if (wrap) m_duty[c] = tgt;
`endif
            end
            if (!activ || wrap) begin
                m_cnt = 0;
                m_per = int'(period);
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    end

    wire [VW-1:0] w_got = {pwm_a, pwm_b, cnt_out, period_start};
    wire [VW-1:0] w_exp = {m_a, m_b, CNT_W'(m_cnt), activ && reset_n && (m_cnt == 0)};

    task automatic test_reset();
        #5 reset_n = 1'b0;
        @(negedge clock);
        n_chk++;
        if (w_got !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected 0", w_got);
        end
        activ  = 1'b0;
        period = 12'd9;
        dir    = '0;
        reset_n = 1'b1;
        @(negedge clock);
        n_chk++;
        if (w_got !== w_exp) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected %h", w_got, w_exp);
        end
    endtask

    task automatic test_basic();
        int hi_a0 = 0, ps = 0, b0 = 0;
        int d1 = $urandom_range(0, 12);
        period = 12'd9;
        duty[0 +: CNT_W]     = 12'd3;
        duty[CNT_W +: CNT_W] = CNT_W'(d1);
        dir   = '0;
        activ = 1'b0;
        @(negedge clock);
        activ = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock);
            n_chk++;
            if (w_got !== w_exp) begin
                n_fail++;
                $display("FAIL basic_cycle %0d: got %h expected %h", k, w_got, w_exp);
            end
            hi_a0 += int'(pwm_a[0]);
            ps    += int'(period_start);
            b0    += int'(pwm_b[0]);
        end
        n_chk++;
        if (hi_a0 != 9) begin n_fail++; $display("FAIL basic_duty3_highs: got %0d expected 9", hi_a0); end
        n_chk++;
        if (ps != 3) begin n_fail++; $display("FAIL basic_period_start: got %0d expected 3", ps); end
        n_chk++;
        if (b0 != 0) begin n_fail++; $display("FAIL basic_pwm_b0: got %0d expected 0", b0); end
    endtask

    task automatic test_duty_change();
        int hi_old = 0, hi_new = 0, hi_c1 = 0;
        int d1 = int'(duty[CNT_W +: CNT_W]);
        n_chk++;
        if (cnt_out !== '0) begin n_fail++; $display("FAIL dchg_align: got %0d expected 0", cnt_out); end
        @(negedge clock);
        duty[0 +: CNT_W] = 12'd7;
        for (int k = 2; k <= 20; k++) begin
            @(negedge clock);
            n_chk++;
            if (w_got !== w_exp) begin
                n_fail++;
                $display("FAIL dchg_cycle %0d: got %h expected %h", k, w_got, w_exp);
            end
            if (k <= 10) hi_old += int'(pwm_a[0]);
            else begin
                hi_new += int'(pwm_a[0]);
                hi_c1  += int'(pwm_a[1]);
            end
        end
        n_chk++;
        if (hi_old != 2) begin n_fail++; $display("FAIL dchg_old_tail: got %0d expected 2", hi_old); end
        n_chk++;
        if (hi_new != 7) begin n_fail++; $display("FAIL dchg_new_period: got %0d expected 7", hi_new); end
        n_chk++;
        if (hi_c1 != ((d1 > 10) ? 10 : d1)) begin
            n_fail++;
            $display("FAIL dchg_ch1: got %0d expected %0d", hi_c1, (d1 > 10) ? 10 : d1);
        end
    endtask

    task automatic test_full_zero();
        int hi_full = 0, hi_zero = 0;
        n_chk++;
        if (cnt_out !== '0) begin n_fail++; $display("FAIL fz_align: got %0d expected 0", cnt_out); end
        duty[0 +: CNT_W] = 12'd10;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            n_chk++;
            if (w_got !== w_exp) begin
                n_fail++;
                $display("FAIL fz_cycle %0d: got %h expected %h", k, w_got, w_exp);
            end
            if (k >= 11 && k <= 30) hi_full += int'(pwm_a[0]);
            if (k >= 31) hi_zero += int'(pwm_a[0]);
            if (k == 25) duty[0 +: CNT_W] = 12'd0;
        end
        n_chk++;
        if (hi_full != 20) begin n_fail++; $display("FAIL fz_no_gap: got %0d expected 20", hi_full); end
        n_chk++;
        if (hi_zero != 0) begin n_fail++; $display("FAIL fz_zero: got %0d expected 0", hi_zero); end
    endtask

    task automatic test_dir();
        int first_b = -1, a_hi = 0, ovl = 0;
        n_chk++;
        if (cnt_out !== '0) begin n_fail++; $display("FAIL dir_align: got %0d expected 0", cnt_out); end
        duty[0 +: CNT_W] = 12'd5;
        repeat (10) @(negedge clock);
        dir[0] = 1'b1;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clock);
            n_chk++;
            if (w_got !== w_exp) begin
                n_fail++;
                $display("FAIL dir_cycle %0d: got %h expected %h", k, w_got, w_exp);
            end
            if (pwm_b[0] && first_b < 0) first_b = k;
            a_hi += int'(pwm_a[0]);
            if ((pwm_a & pwm_b) != '0) ovl++;
        end
        n_chk++;
        if (first_b != DEAD_CYC + 1) begin
            n_fail++;
            $display("FAIL dir_dead_len: got first pwm_b at %0d expected %0d", first_b, DEAD_CYC + 1);
        end
        n_chk++;
        if (a_hi != 0) begin n_fail++; $display("FAIL dir_pwm_a_quiet: got %0d expected 0", a_hi); end
        n_chk++;
        if (ovl != 0) begin n_fail++; $display("FAIL dir_overlap: got %0d expected 0", ovl); end
    endtask

    task automatic test_async_reset();
        bit found = 1'b0;
        int hi_pre = 0, hi_post = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clock);
            if (pwm_b[0]) found = 1'b1;
        end
        n_chk++;
        if (!found) begin n_fail++; $display("FAIL areset_pulse_wait: got none expected pwm_b[0] pulse"); end
        #3 reset_n = 1'b0;
        dir = '0;
        #1;
        n_chk++;
        if (w_got !== '0) begin n_fail++; $display("FAIL areset_immediate: got %h expected 0", w_got); end
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 1; k <= 1010; k++) begin
            @(negedge clock);
            n_chk++;
            if (w_got !== w_exp) begin
                n_fail++;
                $display("FAIL areset_cycle %0d: got %h expected %h", k, w_got, w_exp);
            end
            if (k <= 1000) hi_pre += int'(pwm_a[0]);
            else hi_post += int'(pwm_a[0]);
            if (k == 999) begin
                n_chk++;
                if (cnt_out !== 12'd999) begin
                    n_fail++;
                    $display("FAIL areset_period_rst: got %0d expected 999", cnt_out);
                end
            end
        end
        n_chk++;
        if (hi_pre != 0) begin n_fail++; $display("FAIL areset_duty0: got %0d expected 0", hi_pre); end
        n_chk++;
        if (hi_post != 5) begin n_fail++; $display("FAIL areset_first_wrap: got %0d expected 5", hi_post); end
    endtask

    task automatic test_random();
        int ovl = 0;
        for (int k = 1; k <= 600; k++) begin
            if ($urandom_range(0, 9) == 0) period = CNT_W'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) duty[0 +: CNT_W]     = CNT_W'($urandom_range(0, 17));
            if ($urandom_range(0, 7) == 0) duty[CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 17));
            if ($urandom_range(0, 39) == 0) dir = NUM_CH'($urandom);
            if ($urandom_range(0, 49) == 0) activ = ~activ;
            @(negedge clock);
            n_chk++;
            if (w_got !== w_exp) begin
                n_fail++;
                $display("FAIL rand_cycle %0d: got %h expected %h", k, w_got, w_exp);
            end
            if ((pwm_a & pwm_b) != '0) ovl++;
        end
        n_chk++;
        if (ovl != 0) begin n_fail++; $display("FAIL rand_overlap: got %0d expected 0", ovl); end
    endtask

`ifdef PWM_RAMP_EN
    task automatic test_ramp();
        int exp_hi [6] = '{0, 8, 16, 24, 30, 30};
        int hi;
        activ  = 1'b0;
        dir    = '0;
        period = 12'd99;
        duty[0 +: CNT_W] = 12'd0;
        repeat (DEAD_CYC + 10) @(negedge clock);
        activ = 1'b1;
        duty[0 +: CNT_W] = 12'd30;
        for (int w = 0; w < 6; w++) begin
            hi = 0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clock);
                n_chk++;
                if (w_got !== w_exp) begin
                    n_fail++;
                    $display("FAIL ramp_cycle %0d: got %h expected %h", w*100 + k, w_got, w_exp);
                end
                hi += int'(pwm_a[0]);
            end
            n_chk++;
            if (hi != exp_hi[w]) begin
                n_fail++;
                $display("FAIL ramp_period %0d: got %0d expected %0d", w, hi, exp_hi[w]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_duty_change();
        test_full_zero();
        test_dir();
        test_async_reset();
        test_random();
`ifdef PWM_RAMP_EN
        test_ramp();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
